// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: producer-side request channels plus the ROB writeback port.
// The arbiter uses the slave view; producers and the ROB together form the master view.
interface wb_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_error;
  logic [5*NREQ-1:0]  req_ecause;
  logic [7*NREQ-1:0]  req_robid;
  logic [32*NREQ-1:0] req_result;

  logic               wb_valid;
  logic               wb_error;
  logic [4:0]         wb_ecause;
  logic [6:0]         wb_robid;
  logic [31:0]        wb_result;

  modport master (
    output req_valid, req_error, req_ecause, req_robid, req_result,
    input  req_ready,
    input  wb_valid, wb_error, wb_ecause, wb_robid, wb_result
  );

  modport slave (
    input  req_valid, req_error, req_ecause, req_robid, req_result,
    output req_ready,
    output wb_valid, wb_error, wb_ecause, wb_robid, wb_result
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one holding slot per producer, one registered
// writeback per cycle to the ROB, and a flush that drops every in-flight result.
module wb_arbiter #(
  parameter int NREQ = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rob_flush,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] slot_full;
  logic [NREQ-1:0] slot_error;
  logic [4:0]      slot_ecause [NREQ];
  logic [6:0]      slot_robid  [NREQ];
  logic [31:0]     slot_result [NREQ];

  logic [NREQ-1:0] beat;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   rr_ptr_next;

  logic            sel_error;
  logic [4:0]      sel_ecause;
  logic [6:0]      sel_robid;
  logic [31:0]     sel_result;

  logic            wb_valid_reg;
  logic            wb_error_reg;
  logic [4:0]      wb_ecause_reg;
  logic [6:0]      wb_robid_reg;
  logic [31:0]     wb_result_reg;

  // A slot can take a new beat when empty, when it is being drained this
  // cycle, or during a flush (the beat is then swallowed).
  assign bus.req_ready = ~slot_full | grant | {NREQ{rob_flush}};
  assign beat          = bus.req_valid & bus.req_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      logic        full_reg;
      logic        error_reg;
      logic [4:0]  ecause_reg;
      logic [6:0]  robid_reg;
      logic [31:0] result_reg;

      // Occupancy: flush empties, a beat fills (even over a same-cycle drain), a grant empties.
      always_ff @(posedge clk) begin
        if (rst) begin
          full_reg <= 1'b0;
        end else if (rob_flush) begin
          full_reg <= 1'b0;
        end else if (beat[gi]) begin
          full_reg <= 1'b1;
        end else if (grant[gi]) begin
          full_reg <= 1'b0;
        end
      end

      // Payload capture on every accepted beat; contents are don't-care while empty.
      always_ff @(posedge clk) begin
        if (rst) begin
          error_reg  <= 1'b0;
          ecause_reg <= '0;
          robid_reg  <= '0;
          result_reg <= '0;
        end else if (beat[gi]) begin
          error_reg  <= bus.req_error[gi];
          ecause_reg <= bus.req_ecause[5*gi +: 5];
          robid_reg  <= bus.req_robid[7*gi +: 7];
          result_reg <= bus.req_result[32*gi +: 32];
        end
      end

      assign slot_full[gi]   = full_reg;
      assign slot_error[gi]  = error_reg;
      assign slot_ecause[gi] = ecause_reg;
      assign slot_robid[gi]  = robid_reg;
      assign slot_result[gi] = result_reg;
    end
  endgenerate

  int  scan_idx;
  logic found;

  // Grant the first full slot starting at rr_ptr and wrapping; nothing during a flush.
  always_comb begin
    grant       = '0;
    rr_ptr_next = rr_ptr_reg;
    found       = 1'b0;
    scan_idx    = 0;
    if (!rob_flush) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = int'(rr_ptr_reg) + k;
        if (scan_idx >= NREQ) begin
          scan_idx = scan_idx - NREQ;
        end
        if (!found && slot_full[scan_idx]) begin
          found           = 1'b1;
          grant[scan_idx] = 1'b1;
          rr_ptr_next     = (scan_idx + 1 == NREQ) ? '0 : PW'(scan_idx + 1);
        end
      end
    end
  end

  // One-hot grant mux of the slot payload onto the writeback path.
  always_comb begin
    sel_error  = 1'b0;
    sel_ecause = '0;
    sel_robid  = '0;
    sel_result = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_error  = sel_error  | slot_error[k];
        sel_ecause = sel_ecause | slot_ecause[k];
        sel_robid  = sel_robid  | slot_robid[k];
        sel_result = sel_result | slot_result[k];
      end
    end
  end

  // Round-robin pointer advances past the winner; flush does not disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Writeback output register: valid pulses per grant, payload holds between grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg  <= 1'b0;
      wb_error_reg  <= 1'b0;
      wb_ecause_reg <= '0;
      wb_robid_reg  <= '0;
      wb_result_reg <= '0;
    end else begin
      wb_valid_reg <= |grant;
      if (|grant) begin
        wb_error_reg  <= sel_error;
        wb_ecause_reg <= sel_ecause;
        wb_robid_reg  <= sel_robid;
        wb_result_reg <= sel_result;
      end
    end
  end

  assign bus.wb_valid  = wb_valid_reg;
  assign bus.wb_error  = wb_error_reg;
  assign bus.wb_ecause = wb_ecause_reg;
  assign bus.wb_robid  = wb_robid_reg;
  assign bus.wb_result = wb_result_reg;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset state, latency, rotation, fairness,
// exception fields, flush and mid-operation reset.
module tb_wb_arbiter;
  localparam int NREQ = 4;

  logic clk;
  logic rst;
  logic rob_flush;

  int n_total;
  int n_bad;

  wb_arbiter_if #(.NREQ(NREQ)) bus ();

  wb_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .rob_flush (rob_flush),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs set after this settle before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid  = '0;
    bus.req_error  = '0;
    bus.req_ecause = '0;
    bus.req_robid  = '0;
    bus.req_result = '0;
  endtask

  task automatic set_req(input int i, input logic err, input logic [4:0] cause,
                         input logic [6:0] robid, input logic [31:0] result);
    bus.req_valid[i]            = 1'b1;
    bus.req_error[i]            = err;
    bus.req_ecause[5*i +: 5]    = cause;
    bus.req_robid[7*i +: 7]     = robid;
    bus.req_result[32*i +: 32]  = result;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    step();
    step();
    rst = 1'b0;
  endtask

  logic [6:0] exp_seq [6];

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rob_flush = 1'b0;
    clear_reqs();

    // Reset state
    do_reset();
    check("reset wb_valid", 64'(bus.wb_valid), 64'd0);
    check("reset req_ready", 64'(bus.req_ready), 64'hF);
    check("reset rr_ptr", 64'(dut.rr_ptr_reg), 64'd0);
    check("reset wb_result", 64'(bus.wb_result), 64'd0);

    // Single request on requester 2
    set_req(2, 1'b0, 5'd0, 7'h15, 32'hDEADBEEF);
    step();
    clear_reqs();
    check("single cyc2 wb_valid", 64'(bus.wb_valid), 64'd0);
    check("single cyc2 ready", 64'(bus.req_ready), 64'hF);
    step();
    check("single cyc3 wb_valid", 64'(bus.wb_valid), 64'd1);
    check("single wb_robid", 64'(bus.wb_robid), 64'h15);
    check("single wb_result", 64'(bus.wb_result), 64'hDEADBEEF);
    check("single rr_ptr", 64'(dut.rr_ptr_reg), 64'd3);
    step();
    check("single cyc4 wb_valid", 64'(bus.wb_valid), 64'd0);

    // Simultaneous beats from all requesters, rr_ptr = 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 7'(10 + i), 32'(100 + i));
    step();
    clear_reqs();
    check("simul cyc2 ready", 64'(bus.req_ready), 64'b0001);
    for (int i = 0; i < NREQ; i++) begin
      step();
      check($sformatf("simul wb_valid %0d", i), 64'(bus.wb_valid), 64'd1);
      check($sformatf("simul wb_robid %0d", i), 64'(bus.wb_robid), 64'(10 + i));
      check($sformatf("simul wb_result %0d", i), 64'(bus.wb_result), 64'(100 + i));
    end
    step();
    check("simul drained wb_valid", 64'(bus.wb_valid), 64'd0);
    check("simul rr_ptr", 64'(dut.rr_ptr_reg), 64'd0);

    // Fairness: requesters 0 and 2 stream continuously
    do_reset();
    set_req(0, 1'b0, 5'd0, 7'h20, 32'h0);
    set_req(2, 1'b0, 5'd0, 7'h22, 32'h2);
    step();
    check("fair ready a", 64'(bus.req_ready), 64'b1011);
    step();
    check("fair ready b", 64'(bus.req_ready), 64'b1110);
    exp_seq[0] = 7'h20; exp_seq[1] = 7'h22; exp_seq[2] = 7'h20;
    exp_seq[3] = 7'h22; exp_seq[4] = 7'h20; exp_seq[5] = 7'h22;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      check($sformatf("fair wb_valid %0d", c), 64'(bus.wb_valid), 64'd1);
      check($sformatf("fair wb_robid %0d", c), 64'(bus.wb_robid), 64'(exp_seq[c]));
    end
    clear_reqs();

    // Exception propagation from requester 1
    do_reset();
    set_req(1, 1'b1, 5'd13, 7'h7F, 32'h1234);
    step();
    clear_reqs();
    step();
    check("exc wb_valid", 64'(bus.wb_valid), 64'd1);
    check("exc wb_error", 64'(bus.wb_error), 64'd1);
    check("exc wb_ecause", 64'(bus.wb_ecause), 64'd13);
    check("exc wb_robid", 64'(bus.wb_robid), 64'h7F);

    // Flush with slots 0,1,3 full and a beat on 2; rr_ptr moved to 2 first
    do_reset();
    set_req(1, 1'b0, 5'd0, 7'h31, 32'h31);
    step();
    clear_reqs();
    step();
    check("flush pre rr_ptr", 64'(dut.rr_ptr_reg), 64'd2);
    set_req(0, 1'b0, 5'd0, 7'h40, 32'h40);
    set_req(1, 1'b0, 5'd0, 7'h41, 32'h41);
    set_req(3, 1'b0, 5'd0, 7'h43, 32'h43);
    step();
    clear_reqs();
    rob_flush = 1'b1;
    set_req(2, 1'b0, 5'd0, 7'h42, 32'h42);
    #1;
    check("flush ready", 64'(bus.req_ready), 64'hF);
    step();
    rob_flush = 1'b0;
    clear_reqs();
    check("flush next wb_valid", 64'(bus.wb_valid), 64'd0);
    check("flush rr_ptr", 64'(dut.rr_ptr_reg), 64'd2);
    check("flush ready after", 64'(bus.req_ready), 64'hF);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("flush quiet %0d", c), 64'(bus.wb_valid), 64'd0);
    end

    // Reset in the middle of traffic
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'd7, 7'(40 + i), 32'(400 + i));
    step();
    step();
    check("midrst pre wb_valid", 64'(bus.wb_valid), 64'd1);
    check("midrst pre ready", 64'(bus.req_ready), 64'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_reqs();
    check("midrst wb_valid", 64'(bus.wb_valid), 64'd0);
    check("midrst ready", 64'(bus.req_ready), 64'hF);
    check("midrst rr_ptr", 64'(dut.rr_ptr_reg), 64'd0);
    check("midrst wb_robid", 64'(bus.wb_robid), 64'd0);
    check("midrst wb_result", 64'(bus.wb_result), 64'd0);
    check("midrst wb_error", 64'(bus.wb_error), 64'd0);
    check("midrst wb_ecause", 64'(bus.wb_ecause), 64'd0);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 7'(50 + i), 32'(500 + i));
    step();
    clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      step();
      check($sformatf("midrst burst valid %0d", i), 64'(bus.wb_valid), 64'd1);
      check($sformatf("midrst burst robid %0d", i), 64'(bus.wb_robid), 64'(50 + i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
